// File: rtl/seven_seg_rx_if.sv
// Multiplexed 7-segment display bus seen by seven_seg_rx: raw segment/select input and decoded byte outputs.
// master drives the display bus and observes results; slave is the receiver.
interface seven_seg_rx_if;
   logic [7:0] seg_in;
   logic [7:0] dout;
   logic       dout_valid;
   logic       seg_err;

   modport master (output seg_in, input dout, dout_valid, seg_err);
   modport slave  (input seg_in, output dout, dout_valid, seg_err);
endinterface

// File: rtl/seven_seg_rx.sv
// Recovers a byte from a 2-digit multiplexed 7-segment bus; latency SETTLE+3 edges from last bus change, no backpressure.
// Optional SEVEN_SEG_RX_DEDUP_EN suppresses frames equal to the last emitted byte.
module seven_seg_rx #(
   parameter int unsigned SETTLE = 4
) (
   input  logic          clk,
   input  logic          rst,
   seven_seg_rx_if.slave bus
);

   localparam logic [0:0] WAIT_MSB = 1'b0;
   localparam logic [0:0] WAIT_LSB = 1'b1;
   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   logic [7:0] sync1_q, sync2_q;
   logic [7:0] cnt_q, cnt_d;
   logic       done_q, done_d;
   logic       strobe;

   logic [0:0] state_q, state_d;
   logic [3:0] msb_q, msb_d;
   logic [7:0] dout_q, dout_d;
   logic       dv_q, dv_d;
   logic       err_q, err_d;

   logic [6:0] pat;
   logic [3:0] nib;
   logic       hit;
   logic       blank;
   logic       sel;
   logic       dup;

`ifdef SEVEN_SEG_RX_DEDUP_EN
   logic       have_q, have_d;
`endif

   // sync1 differing from sync2 means the synchronised value changes on this edge.
   // done_q starts set so the idle blank bus is not sampled straight out of reset.
   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      strobe = 1'b0;
      if (sync1_q != sync2_q) begin
         cnt_d  = 8'd0;
         done_d = 1'b0;
      end else if (cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
      if (cnt_q == SETTLE_C && !done_q) begin
         strobe = 1'b1;
         if (sync1_q == sync2_q) begin
            done_d = 1'b1;
         end
      end
   end

   always_comb begin
      pat   = ~sync2_q[6:0];
      sel   = sync2_q[7];
      blank = (sync2_q[6:0] == 7'h7F);
      hit   = 1'b1;
      nib   = 4'h0;
      case (pat)
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h6F: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         default: hit = 1'b0;
      endcase
   end

`ifdef SEVEN_SEG_RX_DEDUP_EN
   assign dup = have_q && ({msb_q, nib} == dout_q);
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      msb_d   = msb_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      err_d   = 1'b0;
`ifdef SEVEN_SEG_RX_DEDUP_EN
      have_d  = have_q;
`endif
      if (strobe && !blank) begin
         if (!hit) begin
            err_d   = 1'b1;
            msb_d   = 4'h0;
            state_d = WAIT_MSB;
         end else if (!sel) begin
            msb_d   = nib;
            state_d = WAIT_LSB;
         end else if (state_q == WAIT_LSB) begin
            state_d = WAIT_MSB;
            if (!dup) begin
               dout_d = {msb_q, nib};
               dv_d   = 1'b1;
`ifdef SEVEN_SEG_RX_DEDUP_EN
               have_d = 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 8'h7F;
         sync2_q <= 8'h7F;
         cnt_q   <= 8'd0;
         done_q  <= 1'b1;
         state_q <= WAIT_MSB;
         msb_q   <= 4'h0;
         dout_q  <= 8'h00;
         dv_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef SEVEN_SEG_RX_DEDUP_EN
         have_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= bus.seg_in;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         state_q <= state_d;
         msb_q   <= msb_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         err_q   <= err_d;
`ifdef SEVEN_SEG_RX_DEDUP_EN
         have_q  <= have_d;
`endif
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dv_q;
   assign bus.seg_err    = err_q;

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed bench for seven_seg_rx (SETTLE=4); expected bytes hand-decoded from the segment table.
module tb_seven_seg_rx;

   logic clk;
   logic rst;
   seven_seg_rx_if bus ();

   seven_seg_rx #(.SETTLE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int dv_tot  = 0;
   int err_tot = 0;
   int both_tot = 0;
   int last_dv_cyc = 0;
   int chg_cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.dout_valid) begin
         dv_tot++;
         last_dv_cyc = cyc;
      end
      if (bus.seg_err) err_tot++;
      if (bus.dout_valid && bus.seg_err) both_tot++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic [7:0] v, input int n);
      bus.seg_in = v;
      chg_cyc = cyc;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_dout", 32'(bus.dout), 32'h00);
      check("rst_dv", 32'(bus.dout_valid), 32'h0);
      check("rst_err", 32'(bus.seg_err), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int dv0, err0;
   int exp_dup;

   initial begin
      rst = 1'b1;
      bus.seg_in = 8'h7F;
      repeat (3) @(posedge clk);
      #1;
      check("por_dout", 32'(bus.dout), 32'h00);
      check("por_dv", 32'(bus.dout_valid), 32'h0);
      rst = 1'b0;

      // basic frame "42" with latency
      dv0 = dv_tot; err0 = err_tot;
      hold(8'h19, 10);
      hold(8'hA4, 10);
      check("basic_dv", 32'(dv_tot - dv0), 32'd1);
      check("basic_dout", 32'(bus.dout), 32'h42);
      check("basic_lat", 32'(last_dv_cyc - chg_cyc), 32'd7);
      check("basic_err", 32'(err_tot - err0), 32'd0);

      // short glitch between digits
      dv0 = dv_tot; err0 = err_tot;
      hold(8'h19, 10);
      hold(8'h00, 3);
      hold(8'hA4, 10);
      check("glitch_dv", 32'(dv_tot - dv0), 32'd1);
      check("glitch_dout", 32'(bus.dout), 32'h42);
      check("glitch_err", 32'(err_tot - err0), 32'd0);

      // unknown pattern alone, then frame "A7"
      dv0 = dv_tot; err0 = err_tot;
      hold(8'h7E, 10);
      check("bad_err", 32'(err_tot - err0), 32'd1);
      check("bad_dv", 32'(dv_tot - dv0), 32'd0);
      check("bad_dout", 32'(bus.dout), 32'h42);
      hold(8'h08, 10);
      hold(8'hF8, 10);
      check("a7_dout", 32'(bus.dout), 32'hA7);
      check("a7_dv", 32'(dv_tot - dv0), 32'd1);

      // blank between digits ignored: "F0"
      dv0 = dv_tot; err0 = err_tot;
      hold(8'h0E, 10);
      hold(8'h7F, 10);
      hold(8'hC0, 10);
      check("blank_dout", 32'(bus.dout), 32'hF0);
      check("blank_dv", 32'(dv_tot - dv0), 32'd1);
      check("blank_err", 32'(err_tot - err0), 32'd0);

      // second MSB overwrites first: "A7"
      dv0 = dv_tot;
      hold(8'h19, 10);
      hold(8'h08, 10);
      hold(8'hF8, 10);
      check("ovr_dout", 32'(bus.dout), 32'hA7);
      check("ovr_dv", 32'(dv_tot - dv0), 32'd1);

      // bad pattern discards held MSB
      dv0 = dv_tot; err0 = err_tot;
      hold(8'h19, 10);
      hold(8'h7E, 10);
      hold(8'hA4, 10);
      check("discard_err", 32'(err_tot - err0), 32'd1);
      check("discard_dv", 32'(dv_tot - dv0), 32'd0);
      check("discard_dout", 32'(bus.dout), 32'hA7);

      // leading LSB ignored after reset
      do_reset();
      dv0 = dv_tot;
      hold(8'hA4, 10);
      hold(8'h19, 10);
      hold(8'hA4, 10);
      check("lsbfirst_dv", 32'(dv_tot - dv0), 32'd1);
      check("lsbfirst_dout", 32'(bus.dout), 32'h42);

      // repeated frame
      do_reset();
      dv0 = dv_tot;
      hold(8'h19, 10);
      hold(8'hA4, 10);
      hold(8'h19, 10);
      hold(8'hA4, 10);
`ifdef SEVEN_SEG_RX_DEDUP_EN
      exp_dup = 1;
`else
      exp_dup = 2;
`endif
      check("repeat_dv", 32'(dv_tot - dv0), 32'(exp_dup));
      check("repeat_dout", 32'(bus.dout), 32'h42);

      // reset between MSB capture and LSB
      hold(8'h19, 10);
      bus.seg_in = 8'hA4;
      do_reset();
      dv0 = dv_tot;
      hold(8'hA4, 10);
      check("midrst_dv", 32'(dv_tot - dv0), 32'd0);
      check("midrst_dout", 32'(bus.dout), 32'h00);

      check("dv_err_overlap", 32'(both_tot), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
